control_state_reg: RTL and testbench

CONTROL_STATE_REG -- requirements
Module: control_state_reg

---
 rtl/control_state_reg.sv | 127 ++++++++++++
 tb/tb_control_state_reg.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/control_state_reg.sv
// control_state_reg
//   Registered state word for a split FSM. The next-state logic lives
//   elsewhere and drives NS. This block holds the current state and the
//   state it held before the last change. It also reports a one-cycle
//   change pulse, counts cycles spent in the current state (saturating),
//   and raises a sticky timeout flag once that count reaches TIMEOUT.
//
// Parameters
//   STATE_W     width of the state word (1..16)
//   RESET_STATE state value loaded by reset
//   DWELL_W     width of the dwell counter (2..32)
//   TIMEOUT     dwell count that raises timeout; 0 disables it
//
// Ports
//   clk_main    system clock, rising edge
//   reset       synchronous active-high reset
//   en          load NS at the next edge
//   NS          next-state value from the FSM logic
//   force_load  override: load force_state (wins over en). "force" is a
//               reserved word in SystemVerilog, hence this name
//   force_state value loaded when force_load=1
//   state       current state
//   prev_state  state held before the most recent change
//   changed     one-cycle pulse: state changed at the last edge
//   dwell       cycles spent in the current state, saturating
//   timeout     sticky: dwell reached TIMEOUT in the current state
//
// All outputs come straight from flops.
module control_state_reg #(
  parameter int unsigned STATE_W     = 4,
  parameter int unsigned RESET_STATE = 0,
  parameter int unsigned DWELL_W     = 16,
  parameter int unsigned TIMEOUT     = 1000
) (
  input  logic               clk_main,
  input  logic               reset,
  input  logic               en,
  input  logic [STATE_W-1:0] NS,
  input  logic               force_load,
  input  logic [STATE_W-1:0] force_state,
  output logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] prev_state,
  output logic               changed,
  output logic [DWELL_W-1:0] dwell,
  output logic               timeout
);

  localparam logic [STATE_W-1:0] RST_VAL   = STATE_W'(RESET_STATE);
  localparam logic [DWELL_W-1:0] DWELL_MAX = {DWELL_W{1'b1}};
  // Compare against TIMEOUT-1 so the flag rises at the same edge where
  // dwell becomes TIMEOUT, instead of one cycle after.
  localparam logic [DWELL_W-1:0] TO_PRE    =
      (TIMEOUT == 0) ? '0 : DWELL_W'(TIMEOUT - 1);

  logic [STATE_W-1:0] state_reg, state_next;
  logic [STATE_W-1:0] prev_reg, prev_next;
  logic               changed_reg, changed_next;
  logic [DWELL_W-1:0] dwell_reg, dwell_next;
  logic               timeout_reg, timeout_next;

  logic [STATE_W-1:0] cand;
  logic               is_change;

  // Candidate value: force beats en, otherwise hold the current state.
  // Reset is applied in the register process, so it has the top priority.
  always_comb begin
    cand = state_reg;
    if (force_load) begin
      cand = force_state;
    end else if (en) begin
      cand = NS;
    end
  end

  // Reloading the value already held does not count as a change.
  assign is_change = (cand != state_reg);

  always_comb begin
    state_next   = state_reg;
    prev_next    = prev_reg;
    changed_next = 1'b0;
    dwell_next   = dwell_reg;
    timeout_next = timeout_reg;
    if (is_change) begin
      state_next   = cand;
      prev_next    = state_reg;
      changed_next = 1'b1;
      dwell_next   = '0;
      // A change wins over a threshold hit at the same edge.
      timeout_next = 1'b0;
    end else begin
      if (dwell_reg != DWELL_MAX) begin
        dwell_next = dwell_reg + 1'b1;
      end
      if (TIMEOUT != 0 && dwell_reg == TO_PRE) begin
        timeout_next = 1'b1;
      end
    end
    // With the timeout disabled the flag is tied low.
    if (TIMEOUT == 0) begin
      timeout_next = 1'b0;
    end
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      state_reg   <= RST_VAL;
      prev_reg    <= RST_VAL;
      changed_reg <= 1'b0;
      dwell_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      prev_reg    <= prev_next;
      changed_reg <= changed_next;
      dwell_reg   <= dwell_next;
      timeout_reg <= timeout_next;
    end
  end

  assign state      = state_reg;
  assign prev_state = prev_reg;
  assign changed    = changed_reg;
  assign dwell      = dwell_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_control_state_reg.sv
// Testbench for control_state_reg.
//   dut_a: STATE_W=4, RESET_STATE=0, DWELL_W=16, TIMEOUT=4
//   dut_b: STATE_W=4, RESET_STATE=3, DWELL_W=3,  TIMEOUT=0 (saturation)
// Inputs are driven 1 time unit after the rising edge. Outputs are
// checked at that point, so they show the result of that edge.
module tb_control_state_reg;

  logic       clk_main = 1'b0;
  always #5 clk_main = ~clk_main;

  logic       reset_a, en_a, force_a;
  logic [3:0] ns_a, fs_a;
  logic [3:0] state_a, prev_a;
  logic       changed_a, timeout_a;
  logic [15:0] dwell_a;

  logic       reset_b, en_b, force_b;
  logic [3:0] ns_b, fs_b;
  logic [3:0] state_b, prev_b;
  logic       changed_b, timeout_b;
  logic [2:0] dwell_b;

  int checks   = 0;
  int failures = 0;

  control_state_reg #(
    .STATE_W(4), .RESET_STATE(0), .DWELL_W(16), .TIMEOUT(4)
  ) dut_a (
    .clk_main(clk_main), .reset(reset_a), .en(en_a), .NS(ns_a),
    .force_load(force_a), .force_state(fs_a),
    .state(state_a), .prev_state(prev_a), .changed(changed_a),
    .dwell(dwell_a), .timeout(timeout_a)
  );

  control_state_reg #(
    .STATE_W(4), .RESET_STATE(3), .DWELL_W(3), .TIMEOUT(0)
  ) dut_b (
    .clk_main(clk_main), .reset(reset_b), .en(en_b), .NS(ns_b),
    .force_load(force_b), .force_state(fs_b),
    .state(state_b), .prev_state(prev_b), .changed(changed_b),
    .dwell(dwell_b), .timeout(timeout_b)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_main);
    #1;
  endtask

  // All outputs of dut_a in one go, with one log line per transaction.
  task automatic chk_a(input string tag, input logic [3:0] st,
                       input logic [3:0] pv, input logic ch,
                       input logic [15:0] dw, input logic to);
    check({tag, ".state"},   32'(state_a),   32'(st));
    check({tag, ".prev"},    32'(prev_a),    32'(pv));
    check({tag, ".changed"}, 32'(changed_a), 32'(ch));
    check({tag, ".dwell"},   32'(dwell_a),   32'(dw));
    check({tag, ".timeout"}, 32'(timeout_a), 32'(to));
    $display("txn %-10s state=%h prev=%h changed=%b dwell=%0d timeout=%b",
             tag, state_a, prev_a, changed_a, dwell_a, timeout_a);
  endtask

  task automatic set_a(input logic r, input logic e, input logic [3:0] n,
                       input logic f, input logic [3:0] s);
    reset_a = r; en_a = e; ns_a = n; force_a = f; fs_a = s;
  endtask

  initial begin
    set_a(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    reset_b = 1'b1; en_b = 1'b0; ns_b = 4'h0; force_b = 1'b0; fs_b = 4'h0;
    #1;

    // Reset state
    step();
    chk_a("reset", 4'h0, 4'h0, 1'b0, 16'd0, 1'b0);

    // Basic load
    set_a(1'b0, 1'b1, 4'h5, 1'b0, 4'h0); step();
    chk_a("load5", 4'h5, 4'h0, 1'b1, 16'd0, 1'b0);
    set_a(1'b0, 1'b0, 4'h0, 1'b0, 4'h0); step();
    chk_a("hold1", 4'h5, 4'h0, 1'b0, 16'd1, 1'b0);

    // Reloading the same value: no change; timeout rises as dwell hits 4
    set_a(1'b0, 1'b1, 4'h5, 1'b0, 4'h0); step();
    chk_a("same1", 4'h5, 4'h0, 1'b0, 16'd2, 1'b0);
    step();
    chk_a("same2", 4'h5, 4'h0, 1'b0, 16'd3, 1'b0);
    step();
    chk_a("same3", 4'h5, 4'h0, 1'b0, 16'd4, 1'b1);
    set_a(1'b0, 1'b0, 4'h0, 1'b0, 4'h0); step();
    chk_a("sticky", 4'h5, 4'h0, 1'b0, 16'd5, 1'b1);

    // Force beats en; the change clears the timeout
    set_a(1'b0, 1'b1, 4'h3, 1'b1, 4'hA); step();
    chk_a("force", 4'hA, 4'h5, 1'b1, 16'd0, 1'b0);

    // Back-to-back changes
    set_a(1'b0, 1'b1, 4'h3, 1'b0, 4'h0); step();
    chk_a("b2b1", 4'h3, 4'hA, 1'b1, 16'd0, 1'b0);
    set_a(1'b0, 1'b1, 4'h7, 1'b0, 4'h0); step();
    chk_a("b2b2", 4'h7, 4'h3, 1'b1, 16'd0, 1'b0);

    // Dwell sequence up to and past the timeout
    set_a(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    step(); chk_a("dw1", 4'h7, 4'h3, 1'b0, 16'd1, 1'b0);
    step(); chk_a("dw2", 4'h7, 4'h3, 1'b0, 16'd2, 1'b0);
    step(); chk_a("dw3", 4'h7, 4'h3, 1'b0, 16'd3, 1'b0);
    step(); chk_a("dw4", 4'h7, 4'h3, 1'b0, 16'd4, 1'b1);
    step(); chk_a("dw5", 4'h7, 4'h3, 1'b0, 16'd5, 1'b1);
    step(); chk_a("dw6", 4'h7, 4'h3, 1'b0, 16'd6, 1'b1);

    // Reset mid-dwell with the timeout high and force asserted
    set_a(1'b1, 1'b0, 4'h0, 1'b1, 4'hA); step();
    chk_a("rst_mid", 4'h0, 4'h0, 1'b0, 16'd0, 1'b0);
    set_a(1'b0, 1'b0, 4'h0, 1'b0, 4'h0); step();
    chk_a("post_rst", 4'h0, 4'h0, 1'b0, 16'd1, 1'b0);
    step(); chk_a("pr2", 4'h0, 4'h0, 1'b0, 16'd2, 1'b0);
    step(); chk_a("pr3", 4'h0, 4'h0, 1'b0, 16'd3, 1'b0);

    // A change and the threshold at the same edge: the change wins
    set_a(1'b0, 1'b1, 4'h9, 1'b0, 4'h0); step();
    chk_a("coincide", 4'h9, 4'h0, 1'b1, 16'd0, 1'b0);

    // Forcing the current value is not a change
    set_a(1'b0, 1'b0, 4'h0, 1'b1, 4'h9); step();
    chk_a("force_same", 4'h9, 4'h0, 1'b0, 16'd1, 1'b0);
    set_a(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);

    // dut_b: reset value 3, 3-bit dwell saturates at 7, timeout disabled
    reset_b = 1'b1; step();
    check("b.reset.state", 32'(state_b), 32'h3);
    check("b.reset.prev", 32'(prev_b), 32'h3);
    check("b.reset.changed", 32'(changed_b), 32'h0);
    $display("txn b.reset   state=%h prev=%h dwell=%0d", state_b, prev_b, dwell_b);
    reset_b = 1'b0; en_b = 1'b1; ns_b = 4'h3;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("b.sat%0d.dwell", i), 32'(dwell_b), (i > 7) ? 32'd7 : 32'(i));
      check($sformatf("b.sat%0d.timeout", i), 32'(timeout_b), 32'h0);
      check($sformatf("b.sat%0d.changed", i), 32'(changed_b), 32'h0);
      $display("txn b.sat%0d    state=%h dwell=%0d timeout=%b", i, state_b, dwell_b, timeout_b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
